mem_wb_sequencer: RTL

- Executes the control bundle produced by the opcode decoder: the memory-access and write-back end of the control interface.
- Accepts one decoded instruction at a time over a valid/ready handshake and drives a handshaked data-memory port.
- Performs register-file write-back of either the ALU result or the loaded data.
- Sits between the execute stage and the register file of the multi-cycle datapath.

---
 rtl/mem_wb_pkg.sv | 18 +
 rtl/mem_wb_timeout.sv | 29 ++
 rtl/mem_wb_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the memory-access / write-back sequencer.
package mem_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  localparam int unsigned DATA_W_DEF      = 32;
  localparam int unsigned ADDR_W_DEF      = 32;
  localparam int unsigned REG_AW_DEF      = 5;
  localparam int unsigned TIMEOUT_CYC_DEF = 16;

  // Architectural zero register: never written.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/mem_wb_timeout.sv
// Memory wait counter; flags expiry when the limit is reached without an ack.
// Instantiated by mem_wb_sequencer only when MEM_TIMEOUT_EN is defined.
module mem_wb_timeout #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state is always assigned with <= so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n)   cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
    else          cnt <= '0;
  end

  // cnt counts completed request cycles, so the final allowed cycle is LIMIT-1;
  // an ack in that same cycle wins.
  assign expired = run && !ack && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_wb_sequencer.sv
// Memory-access and write-back sequencer for the multi-cycle datapath.
// Optional memory wait timeout enabled with `define MEM_TIMEOUT_EN.
module mem_wb_sequencer
  import mem_wb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned REG_AW      = REG_AW_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ctl_valid,
  output logic              ctl_ready,
  input  logic              mem_to_reg,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [REG_AW-1:0] rd_addr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              err
);

  state_t state, state_nxt;

  logic              mem_to_reg_q;
  logic              mem_write_q;
  logic              reg_write_q;
  logic [DATA_W-1:0] alu_q;
  logic [DATA_W-1:0] store_q;
  logic [DATA_W-1:0] rdata_q;
  logic [REG_AW-1:0] rd_q;

  logic accept;
  logic timed_out;

  assign accept = (state == ST_IDLE) && ctl_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (ctl_valid) begin
          if (mem_write || mem_to_reg) state_nxt = ST_MEM;
          else if (reg_write)          state_nxt = ST_WB;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          // A store wins over any write-back request.
          if (mem_write_q)      state_nxt = ST_IDLE;
          else if (reg_write_q) state_nxt = ST_WB;
          else                  state_nxt = ST_IDLE;
        end else if (timed_out) begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WB:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand registers only load on a transfer, so memory-port outputs stay
  // stable for the whole request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_q        <= '0;
      store_q      <= '0;
      rd_q         <= '0;
    end else if (accept) begin
      mem_to_reg_q <= mem_to_reg;
      mem_write_q  <= mem_write;
      reg_write_q  <= reg_write;
      alu_q        <= alu_result;
      store_q      <= store_data;
      rd_q         <= rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                           rdata_q <= '0;
    else if ((state == ST_MEM) && mem_ack && !mem_write_q) rdata_q <= mem_rdata;
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_wb_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     (state == ST_MEM),
    .ack     (mem_ack),
    .expired (timed_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n)         err_q <= 1'b0;
    else if (timed_out) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign timed_out = 1'b0;
  assign err       = 1'b0;
`endif

  generate
    if (ADDR_W <= DATA_W) begin : g_addr_trunc
      assign mem_addr = alu_q[ADDR_W-1:0];
    end else begin : g_addr_zext
      assign mem_addr = {{(ADDR_W - DATA_W){1'b0}}, alu_q};
    end
  endgenerate

  assign ctl_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign mem_req   = (state == ST_MEM);
  assign mem_we    = (state == ST_MEM) && mem_write_q;
  assign mem_wdata = store_q;

  assign rf_we    = (state == ST_WB) && (rd_q != REG_AW'(REG_ZERO));
  assign rf_waddr = rd_q;
  assign rf_wdata = mem_to_reg_q ? rdata_q : alu_q;

endmodule
